dmem_arbiter: RTL and testbench

//  Shares the single data_memory port between the ARM core (load/store) and a VGA framebuffer fetch port.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arb_wait_ctr.sv | 41 ++++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the ARM core and the VGA fetch port.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_CPU   = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // Saturating increment used by the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        if (en && (val != STAT_MAX)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Counts consecutive VGA cycles lost to the CPU; hit flags the loss that must trigger a forced grant.
module dmem_arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic lose,
    input  logic clr,
    output logic hit
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (lose && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With MAX_WAIT=1 LAST_CNT is 0, so every lost cycle forces the next one.
    assign hit = lose && (cnt_q >= LAST_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the CPU (default owner) and the VGA framebuffer fetch port.
// Define DMEM_ARB_STATS_EN to add saturating CPU-owner / VGA-grant / stall cycle counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] FB_BASE  = 'h0000_0100,
    parameter int                MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_cnt,
    output logic [31:0]       stat_vga_cnt,
    output logic [31:0]       stat_stall_cnt
`endif
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    owner_t            owner;
    logic              cpu_acc;
    logic              vga_lose;
    logic              vga_clr;
    logic              force_hit;
    logic              vga_rvalid_q;
    logic [DATA_W-1:0] vga_rdata_q;

    assign cpu_acc = cpu_re | cpu_we;

    // Ownership and stall; reset forces the port idle so no write or grant escapes.
    always_comb begin
        owner     = OWN_NONE;
        cpu_stall = 1'b0;
        case (state_q)
            ARB_CPU: begin
                if (cpu_acc) begin
                    owner = OWN_CPU;
                end else if (vga_req) begin
                    owner = OWN_VGA;
                end
            end
            ARB_FORCE: begin
                if (vga_req) begin
                    owner = OWN_VGA;
                end
                cpu_stall = cpu_acc;
            end
            default: begin
                owner = OWN_NONE;
            end
        endcase
        if (!reset) begin
            owner     = OWN_NONE;
            cpu_stall = 1'b0;
        end
    end

    assign vga_gnt  = (owner == OWN_VGA);
    assign vga_lose = vga_req & ~vga_gnt;
    assign vga_clr  = ~vga_req | vga_gnt;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .reset (reset),
        .lose  (vga_lose),
        .clr   (vga_clr),
        .hit   (force_hit)
    );

    // A forced cycle is always exactly one cycle long, granted or not.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_CPU: begin
                if (force_hit) begin
                    state_d = ARB_FORCE;
                end
            end
            ARB_FORCE: begin
                state_d = ARB_CPU;
            end
            default: begin
                state_d = ARB_CPU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    // Port mux; VGA offsets wrap modulo 2^ADDR_W.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_VGA: begin
                mem_addr = FB_BASE + vga_addr;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign cpu_rdata = (owner == OWN_CPU) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
        end else begin
            vga_rvalid_q <= vga_gnt;
            if (vga_gnt) begin
                vga_rdata_q <= mem_rdata;
            end
        end
    end

    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [2:0] stat_evt;

    assign stat_evt = {cpu_stall, vga_gnt, (owner == OWN_CPU)};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [31:0] cnt_q;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= sat_inc(cnt_q, stat_evt[gi]);
                end
            end
        end
    endgenerate

    assign stat_cpu_cnt   = g_stat[0].cnt_q;
    assign stat_vga_cnt   = g_stat[1].cnt_q;
    assign stat_stall_cnt = g_stat[2].cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a combinational-read data memory model and a VGA read scoreboard.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_cnt;
    logic [31:0] stat_vga_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    logic [31:0] mem [0:1023];
    logic        pl_we;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_cnt   (stat_cpu_cnt),
        .stat_vga_cnt   (stat_vga_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        next_cycle();
        pl_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h20;
        cpu_wdata = 32'hDEAD;
        vga_req   = 1'b1;
        vga_addr  = 32'h10;
        for (int c = 0; c < 2; c++) begin
            #4;
            n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we c=%0d got=%0b exp=0", c, mem_we); end
            n_cmp++; if (vga_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_vga_gnt c=%0d got=%0b exp=0", c, vga_gnt); end
            n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall c=%0d got=%0b exp=0", c, cpu_stall); end
            n_cmp++; if (vga_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid c=%0d got=%0b exp=0", c, vga_rvalid); end
            next_cycle();
        end
        n_cmp++; if (mem[10'h20] !== 32'h11) begin n_bad++; $display("FAIL rst_nowrite got=%0h exp=11", mem[10'h20]); end
        reset    = 1'b1;
        cpu_we   = 1'b0;
        cpu_re   = 1'b1;
        cpu_addr = 32'h40;
        vga_req  = 1'b0;
        #4;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rel_stall got=%0b exp=0", cpu_stall); end
        n_cmp++; if (mem_addr !== 32'h40) begin n_bad++; $display("FAIL rel_cpu_owner got=%0h exp=40", mem_addr); end
        n_cmp++; if (cpu_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rel_cpu_rdata got=%0h exp=12345678", cpu_rdata); end
        n_cmp++; if (dut.u_wait_ctr.cnt_q !== 3'd0) begin n_bad++; $display("FAIL rel_wait_cnt got=%0d exp=0", dut.u_wait_ctr.cnt_q); end
        $display("txn reset: released, cpu load addr=%0h rdata=%0h", mem_addr, cpu_rdata);
        next_cycle();
        cpu_re = 1'b0;
        #4;
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL idle_addr got=%0h exp=0", mem_addr); end
        n_cmp++; if ({mem_we, vga_gnt} !== 2'b00) begin n_bad++; $display("FAIL idle_we_gnt got=%0b exp=00", {mem_we, vga_gnt}); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL idle_cpu_rdata got=%0h exp=0", cpu_rdata); end
        next_cycle();
    endtask

    task automatic test_vga_read();
        vga_req  = 1'b1;
        vga_addr = 32'h10;
        #4;
        n_cmp++; if (vga_gnt !== 1'b1) begin n_bad++; $display("FAIL vga_gnt got=%0b exp=1", vga_gnt); end
        n_cmp++; if (mem_addr !== 32'h110) begin n_bad++; $display("FAIL vga_addr got=%0h exp=110", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL vga_we got=%0b exp=0", mem_we); end
        exp_q.push_back(32'hCAFE);
        next_cycle();
        vga_req = 1'b0;
        #4;
        n_cmp++;
        if (vga_rvalid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL vga_rvalid got=%0b exp=1", vga_rvalid);
        end else begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (vga_rdata !== exp_v) begin n_bad++; $display("FAIL vga_rdata got=%0h exp=%0h", vga_rdata, exp_v); end
        end
        $display("txn vga_read: rdata=%0h", vga_rdata);
        next_cycle();
        #4;
        n_cmp++; if (vga_rvalid !== 1'b0) begin n_bad++; $display("FAIL vga_rvalid_pulse got=%0b exp=0", vga_rvalid); end
        n_cmp++; if (vga_rdata !== 32'hCAFE) begin n_bad++; $display("FAIL vga_rdata_hold got=%0h exp=cafe", vga_rdata); end
        next_cycle();
    endtask

    task automatic test_starvation();
        cpu_re   = 1'b1;
        cpu_addr = 32'h40;
        vga_req  = 1'b1;
        vga_addr = 32'h14;
        for (int k = 0; k < 11; k++) begin
            if (k == 10) begin
                cpu_re  = 1'b0;
                vga_req = 1'b0;
            end
            #4;
            if (vga_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL starve_unexpected_rvalid k=%0d got=1 exp=0", k);
                end else begin
                    exp_v = exp_q.pop_front();
                    n_cmp++; if (vga_rdata !== exp_v) begin n_bad++; $display("FAIL starve_rdata k=%0d got=%0h exp=%0h", k, vga_rdata, exp_v); end
                    $display("txn starve_fetch k=%0d rdata=%0h", k, vga_rdata);
                end
            end
            if (k < 10) begin
                n_cmp++; if (vga_gnt !== (k % 5 == 4)) begin n_bad++; $display("FAIL starve_gnt k=%0d got=%0b exp=%0b", k, vga_gnt, (k % 5 == 4)); end
                n_cmp++; if (cpu_stall !== (k % 5 == 4)) begin n_bad++; $display("FAIL starve_stall k=%0d got=%0b exp=%0b", k, cpu_stall, (k % 5 == 4)); end
                n_cmp++; if (dut.u_wait_ctr.cnt_q !== 3'(k % 5)) begin n_bad++; $display("FAIL starve_wait_cnt k=%0d got=%0d exp=%0d", k, dut.u_wait_ctr.cnt_q, k % 5); end
                n_cmp++; if (cpu_rdata !== ((k % 5 == 4) ? 32'h0 : 32'h1234_5678)) begin n_bad++; $display("FAIL starve_cpu_rdata k=%0d got=%0h", k, cpu_rdata); end
                if (k % 5 == 4) begin
                    exp_q.push_back(32'hBEEF);
                end
            end
            next_cycle();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL starve_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_forced_write();
        cpu_re   = 1'b1;
        cpu_addr = 32'h40;
        vga_req  = 1'b1;
        vga_addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
        end
        cpu_re    = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h20;
        cpu_wdata = 32'h55;
        #4;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL fw_stall got=%0b exp=1", cpu_stall); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL fw_mem_we got=%0b exp=0", mem_we); end
        n_cmp++; if (vga_gnt !== 1'b1) begin n_bad++; $display("FAIL fw_gnt got=%0b exp=1", vga_gnt); end
        exp_q.push_back(32'hCAFE);
        next_cycle();
        #4;
        n_cmp++; if (mem[10'h20] !== 32'h11) begin n_bad++; $display("FAIL fw_unchanged got=%0h exp=11", mem[10'h20]); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL fw_repeat_stall got=%0b exp=0", cpu_stall); end
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL fw_repeat_we got=%0b exp=1", mem_we); end
        n_cmp++;
        if (vga_rvalid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL fw_rvalid got=%0b exp=1", vga_rvalid);
        end else begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (vga_rdata !== exp_v) begin n_bad++; $display("FAIL fw_rdata got=%0h exp=%0h", vga_rdata, exp_v); end
        end
        next_cycle();
        cpu_we  = 1'b0;
        vga_req = 1'b0;
        #4;
        n_cmp++; if (mem[10'h20] !== 32'h55) begin n_bad++; $display("FAIL fw_written got=%0h exp=55", mem[10'h20]); end
        $display("txn forced_write: mem[20]=%0h", mem[10'h20]);
        next_cycle();
    endtask

    task automatic test_reset_in_force();
        cpu_re   = 1'b1;
        cpu_addr = 32'h40;
        vga_req  = 1'b1;
        vga_addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
        end
        reset     = 1'b0;
        cpu_re    = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h30;
        cpu_wdata = 32'h99;
        #4;
        n_cmp++; if (vga_gnt !== 1'b0) begin n_bad++; $display("FAIL rf_gnt got=%0b exp=0", vga_gnt); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rf_stall got=%0b exp=0", cpu_stall); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rf_mem_we got=%0b exp=0", mem_we); end
        next_cycle();
        reset    = 1'b1;
        cpu_we   = 1'b0;
        cpu_re   = 1'b1;
        cpu_addr = 32'h40;
        #4;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rf_after_stall got=%0b exp=0", cpu_stall); end
        n_cmp++; if (vga_rvalid !== 1'b0) begin n_bad++; $display("FAIL rf_after_rvalid got=%0b exp=0", vga_rvalid); end
        n_cmp++; if (dut.u_wait_ctr.cnt_q !== 3'd0) begin n_bad++; $display("FAIL rf_after_wait_cnt got=%0d exp=0", dut.u_wait_ctr.cnt_q); end
        n_cmp++; if (vga_gnt !== 1'b0) begin n_bad++; $display("FAIL rf_after_gnt got=%0b exp=0", vga_gnt); end
        n_cmp++; if (mem[10'h30] !== 32'h77) begin n_bad++; $display("FAIL rf_nowrite got=%0h exp=77", mem[10'h30]); end
        n_cmp++; if (vga_rdata !== 32'h0) begin n_bad++; $display("FAIL rf_rdata_clr got=%0h exp=0", vga_rdata); end
        $display("txn reset_in_force: stall=%0b rvalid=%0b", cpu_stall, vga_rvalid);
        next_cycle();
        cpu_re  = 1'b0;
        vga_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_wrap();
        vga_req  = 1'b1;
        vga_addr = 32'hFFFF_FFF0;
        #4;
        n_cmp++; if (mem_addr !== 32'h0000_00F0) begin n_bad++; $display("FAIL wrap_addr got=%0h exp=f0", mem_addr); end
        n_cmp++; if (vga_gnt !== 1'b1) begin n_bad++; $display("FAIL wrap_gnt got=%0b exp=1", vga_gnt); end
        exp_q.push_back(32'hF00D);
        next_cycle();
        vga_req = 1'b0;
        #4;
        n_cmp++;
        if (vga_rvalid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL wrap_rvalid got=%0b exp=1", vga_rvalid);
        end else begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (vga_rdata !== exp_v) begin n_bad++; $display("FAIL wrap_rdata got=%0h exp=%0h", vga_rdata, exp_v); end
        end
        $display("txn wrap: rdata=%0h", vga_rdata);
        next_cycle();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        reset   = 1'b0;
        cpu_re  = 1'b1;
        vga_req = 1'b1;
        vga_addr = 32'h10;
        next_cycle();
        reset = 1'b1;
        #4;
        n_cmp++; if (stat_cpu_cnt !== 32'd0) begin n_bad++; $display("FAIL stats_reset got=%0d exp=0", stat_cpu_cnt); end
        next_cycle();
        for (int k = 1; k < 10; k++) begin
            next_cycle();
        end
        cpu_re  = 1'b0;
        vga_req = 1'b0;
        #4;
        n_cmp++; if (stat_cpu_cnt !== 32'd8) begin n_bad++; $display("FAIL stats_cpu got=%0d exp=8", stat_cpu_cnt); end
        n_cmp++; if (stat_vga_cnt !== 32'd2) begin n_bad++; $display("FAIL stats_vga got=%0d exp=2", stat_vga_cnt); end
        n_cmp++; if (stat_stall_cnt !== 32'd2) begin n_bad++; $display("FAIL stats_stall got=%0d exp=2", stat_stall_cnt); end
        $display("txn stats: cpu=%0d vga=%0d stall=%0d", stat_cpu_cnt, stat_vga_cnt, stat_stall_cnt);
        next_cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vga_req   = 1'b0;
        vga_addr  = '0;
        pl_we     = 1'b0;
        pl_addr   = '0;
        pl_data   = '0;
        @(posedge clk);
        #1;
        preload(10'h110, 32'hCAFE);
        preload(10'h114, 32'hBEEF);
        preload(10'h040, 32'h1234_5678);
        preload(10'h020, 32'h11);
        preload(10'h030, 32'h77);
        preload(10'h0F0, 32'hF00D);
        test_reset();
        test_vga_read();
        test_starvation();
        test_forced_write();
        test_reset_in_force();
        test_wrap();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
